// File: rtl/rv_trap_pkg.sv
// rv_trap_pkg: shared types and constants for the machine-mode trap sequencer.
//   - trap_state_e : sequencer state encoding
//   - IRQ_CODE_*   : mcause exception codes of the three machine interrupts
//   - MTVEC_*      : mtvec mode field values
//   - cause_word() : builds a 32-bit mcause value from interrupt flag and code
package rv_trap_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StDrain,
      StEnter,
      StExit,
      StRedirect
   } trap_state_e;

   localparam logic [3:0] IRQ_CODE_MEI = 4'd11;
   localparam logic [3:0] IRQ_CODE_MSI = 4'd3;
   localparam logic [3:0] IRQ_CODE_MTI = 4'd7;

   localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
   localparam logic [1:0] MTVEC_VECTORED = 2'b01;

   function automatic logic [31:0] cause_word(input logic is_irq, input logic [3:0] code);
      return {is_irq, 27'b0, code};
   endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: combinational masked priority encoder for machine interrupts.
// Ports:
//   mstatus_mie                    global machine interrupt enable
//   irq_ext / irq_soft / irq_timer raw (or synchronised) request levels
//   en_ext / en_soft / en_timer    mie bits 11 / 3 / 7
//   pending                        at least one enabled request is active
//   code                           mcause code of the winner (ext > soft > timer)
import rv_trap_pkg::*;

module irq_prio_enc (
   input  logic       mstatus_mie,
   input  logic       irq_ext,
   input  logic       irq_soft,
   input  logic       irq_timer,
   input  logic       en_ext,
   input  logic       en_soft,
   input  logic       en_timer,
   output logic       pending,
   output logic [3:0] code
);

   always_comb begin
      pending = 1'b0;
      code    = 4'd0;
      if (mstatus_mie) begin
         if (irq_ext && en_ext) begin
            pending = 1'b1;
            code    = IRQ_CODE_MEI;
         end else if (irq_soft && en_soft) begin
            pending = 1'b1;
            code    = IRQ_CODE_MSI;
         end else if (irq_timer && en_timer) begin
            pending = 1'b1;
            code    = IRQ_CODE_MTI;
         end
      end
   end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: trap entry / MRET sequencer in front of the machine-mode CSR file.
// Arbitrates exceptions, MRET and interrupts, drains and flushes the pipeline, strobes
// interrupt_enter / interrupt_exit with cause/pc/mtval and redirects fetch to the handler
// (direct or vectored mtvec) or to mepc. All outputs are registered.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   i_mstatus_mie, i_mie      interrupt enables from the CSR file
//   i_mtvec, i_mepc           trap vector and return address
//   i_irq_ext/soft/timer      level interrupt requests
//   i_exc_*                   synchronous exception from execute
//   i_mret                    MRET in execute
//   i_commit_valid/npc        retirement stream, tracks the resume PC
//   i_pipe_empty              nothing in flight past fetch
//   o_stall/o_flush           pipeline control
//   o_redirect/o_redirect_pc  fetch redirect
//   o_interrupt_enter/exit    one-cycle strobes to the CSR file
//   o_int_cause/pc/mtval      trap information, valid with o_interrupt_enter
// Build option: define TRAP_IRQ_SYNC_EN to pass each irq through a 2-flop synchroniser.
import rv_trap_pkg::*;

module trap_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned DRAIN_MAX = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_mstatus_mie,
   input  logic [31:0] i_mie,
   input  logic [31:0] i_mtvec,
   input  logic [31:0] i_mepc,
   input  logic        i_irq_ext,
   input  logic        i_irq_soft,
   input  logic        i_irq_timer,
   input  logic        i_exc_valid,
   input  logic [3:0]  i_exc_cause,
   input  logic [31:0] i_exc_pc,
   input  logic [31:0] i_exc_tval,
   input  logic        i_mret,
   input  logic        i_commit_valid,
   input  logic [31:0] i_commit_npc,
   input  logic        i_pipe_empty,
   output logic        o_stall,
   output logic        o_flush,
   output logic        o_redirect,
   output logic [31:0] o_redirect_pc,
   output logic        o_interrupt_enter,
   output logic        o_interrupt_exit,
   output logic [31:0] o_int_cause,
   output logic [31:0] o_int_pc,
   output logic [31:0] o_int_mtval
);

   localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_MAX - 1);

   trap_state_e state_q;
   logic [7:0]  drain_cnt_q;
   logic [31:0] resume_pc_q;
   logic [31:0] resume_pc_d;
   logic        trap_irq_q;
   logic [3:0]  trap_code_q;

   logic [2:0]  irq_vec;
   logic        irq_pending;
   logic [3:0]  irq_code;
   logic [31:0] mtvec_base;
   logic [31:0] handler_pc;

   // Only bits 11/7/3 of mie matter here.
   logic        unused_mie;
   assign unused_mie = ^{i_mie[31:12], i_mie[10:8], i_mie[6:4], i_mie[2:0]};

`ifdef TRAP_IRQ_SYNC_EN
   logic [2:0] irq_sync1_q;
   logic [2:0] irq_sync2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         irq_sync1_q <= 3'b000;
         irq_sync2_q <= 3'b000;
      end else begin
         irq_sync1_q <= {i_irq_ext, i_irq_soft, i_irq_timer};
         irq_sync2_q <= irq_sync1_q;
      end
   end

   assign irq_vec = irq_sync2_q;
`else
   assign irq_vec = {i_irq_ext, i_irq_soft, i_irq_timer};
`endif

   irq_prio_enc u_prio (
      .mstatus_mie (i_mstatus_mie),
      .irq_ext     (irq_vec[2]),
      .irq_soft    (irq_vec[1]),
      .irq_timer   (irq_vec[0]),
      .en_ext      (i_mie[11]),
      .en_soft     (i_mie[3]),
      .en_timer    (i_mie[7]),
      .pending     (irq_pending),
      .code        (irq_code)
   );

   // Resume PC including a commit in the current cycle.
   assign resume_pc_d = i_commit_valid ? i_commit_npc : resume_pc_q;

   // mtvec is sampled during ENTER so the registered redirect target is ready in REDIRECT.
   assign mtvec_base = {i_mtvec[31:2], 2'b00};
   assign handler_pc = (trap_irq_q && (i_mtvec[1:0] == MTVEC_VECTORED)) ?
                       mtvec_base + {26'b0, trap_code_q, 2'b00} : mtvec_base;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q           <= StIdle;
         drain_cnt_q       <= 8'd0;
         resume_pc_q       <= RESET_PC;
         trap_irq_q        <= 1'b0;
         trap_code_q       <= 4'd0;
         o_stall           <= 1'b0;
         o_flush           <= 1'b0;
         o_redirect        <= 1'b0;
         o_redirect_pc     <= 32'd0;
         o_interrupt_enter <= 1'b0;
         o_interrupt_exit  <= 1'b0;
         o_int_cause       <= 32'd0;
         o_int_pc          <= 32'd0;
         o_int_mtval       <= 32'd0;
      end else begin
         resume_pc_q       <= resume_pc_d;
         o_stall           <= 1'b0;
         o_flush           <= 1'b0;
         o_redirect        <= 1'b0;
         o_redirect_pc     <= 32'd0;
         o_interrupt_enter <= 1'b0;
         o_interrupt_exit  <= 1'b0;
         o_int_cause       <= 32'd0;
         o_int_pc          <= 32'd0;
         o_int_mtval       <= 32'd0;

         case (state_q)
            StIdle, StDrain: begin
               if (i_exc_valid) begin
                  // Exception wins; a pending interrupt is re-evaluated after return to IDLE.
                  state_q           <= StEnter;
                  trap_irq_q        <= 1'b0;
                  trap_code_q       <= i_exc_cause;
                  o_interrupt_enter <= 1'b1;
                  o_flush           <= 1'b1;
                  o_stall           <= 1'b1;
                  o_int_cause       <= cause_word(1'b0, i_exc_cause);
                  o_int_pc          <= i_exc_pc;
                  o_int_mtval       <= i_exc_tval;
               end else if (state_q == StIdle) begin
                  if (i_mret) begin
                     state_q          <= StExit;
                     o_interrupt_exit <= 1'b1;
                     o_flush          <= 1'b1;
                     o_stall          <= 1'b1;
                  end else if (irq_pending) begin
                     state_q     <= StDrain;
                     drain_cnt_q <= 8'd0;
                     o_stall     <= 1'b1;
                  end
               end else if (!irq_pending) begin
                  state_q <= StIdle;
               end else if (i_pipe_empty || (drain_cnt_q == DRAIN_LAST)) begin
                  state_q           <= StEnter;
                  trap_irq_q        <= 1'b1;
                  trap_code_q       <= irq_code;
                  o_interrupt_enter <= 1'b1;
                  o_flush           <= 1'b1;
                  o_stall           <= 1'b1;
                  o_int_cause       <= cause_word(1'b1, irq_code);
                  o_int_pc          <= resume_pc_d;
                  o_int_mtval       <= 32'd0;
               end else begin
                  drain_cnt_q <= drain_cnt_q + 8'd1;
                  o_stall     <= 1'b1;
               end
            end
            StEnter: begin
               state_q       <= StRedirect;
               o_redirect    <= 1'b1;
               o_stall       <= 1'b1;
               o_redirect_pc <= handler_pc;
            end
            StExit: begin
               state_q       <= StRedirect;
               o_redirect    <= 1'b1;
               o_stall       <= 1'b1;
               o_redirect_pc <= i_mepc;
            end
            StRedirect: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: randomized scoreboard bench for trap_ctrl. Stimulus tasks compute the
// expected strobes (kind, cycle, cause/pc/mtval, redirect target) from the architectural
// rules and queue them; a negedge monitor pops and compares whenever a strobe appears.
module tb_trap_ctrl;

   localparam int          DM  = 16;
   localparam logic [31:0] RPC = 32'h8000_0000;
`ifdef TRAP_IRQ_SYNC_EN
   localparam int L = 2;
`else
   localparam int L = 0;
`endif
   localparam int K_ENTER = 0;
   localparam int K_EXIT  = 1;
   localparam int K_REDIR = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_mstatus_mie;
   logic [31:0] i_mie, i_mtvec, i_mepc;
   logic        i_irq_ext, i_irq_soft, i_irq_timer;
   logic        i_exc_valid;
   logic [3:0]  i_exc_cause;
   logic [31:0] i_exc_pc, i_exc_tval;
   logic        i_mret, i_commit_valid;
   logic [31:0] i_commit_npc;
   logic        i_pipe_empty;
   logic        o_stall, o_flush, o_redirect, o_interrupt_enter, o_interrupt_exit;
   logic [31:0] o_redirect_pc, o_int_cause, o_int_pc, o_int_mtval;

   trap_ctrl #(
      .RESET_PC  (RPC),
      .DRAIN_MAX (DM)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .i_mstatus_mie     (i_mstatus_mie),
      .i_mie             (i_mie),
      .i_mtvec           (i_mtvec),
      .i_mepc            (i_mepc),
      .i_irq_ext         (i_irq_ext),
      .i_irq_soft        (i_irq_soft),
      .i_irq_timer       (i_irq_timer),
      .i_exc_valid       (i_exc_valid),
      .i_exc_cause       (i_exc_cause),
      .i_exc_pc          (i_exc_pc),
      .i_exc_tval        (i_exc_tval),
      .i_mret            (i_mret),
      .i_commit_valid    (i_commit_valid),
      .i_commit_npc      (i_commit_npc),
      .i_pipe_empty      (i_pipe_empty),
      .o_stall           (o_stall),
      .o_flush           (o_flush),
      .o_redirect        (o_redirect),
      .o_redirect_pc     (o_redirect_pc),
      .o_interrupt_enter (o_interrupt_enter),
      .o_interrupt_exit  (o_interrupt_exit),
      .o_int_cause       (o_int_cause),
      .o_int_pc          (o_int_pc),
      .o_int_mtval       (o_int_mtval)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          kind;
      int          cyc;
      logic [31:0] cause;
      logic [31:0] pc;
      logic [31:0] tval;
      logic [31:0] target;
   } exp_t;

   exp_t        exp_q[$];
   int          checks   = 0;
   int          failures = 0;
   logic        commit_en = 1'b1;
   logic [31:0] last_npc  = RPC;

   function automatic void chk(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=0x%08h expected=0x%08h", name, cyc, act, exp);
      end
   endfunction

   function automatic void push(input int kind, input int c, input logic [31:0] cause,
                                input logic [31:0] pc, input logic [31:0] tval,
                                input logic [31:0] target);
      exp_t e;
      e.kind = kind; e.cyc = c; e.cause = cause; e.pc = pc; e.tval = tval; e.target = target;
      exp_q.push_back(e);
   endfunction

   // ---- reference rules ----
   function automatic logic pend_f(input logic e, input logic s, input logic t);
      return i_mstatus_mie && ((e && i_mie[11]) || (s && i_mie[3]) || (t && i_mie[7]));
   endfunction

   function automatic logic [3:0] code_f(input logic e, input logic s);
      if (e && i_mie[11]) return 4'd11;
      if (s && i_mie[3])  return 4'd3;
      return 4'd7;
   endfunction

   function automatic logic [31:0] tgt_f(input logic is_irq, input logic [3:0] code);
      logic [31:0] base;
      base = i_mtvec & 32'hFFFF_FFFC;
      if (is_irq && i_mtvec[1:0] == 2'b01) return base + 32'(code) * 32'd4;
      return base;
   endfunction

   // ---- monitor ----
   function automatic void take_evt(input int kind);
      exp_t e;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL unexpected_strobe cycle=%0d actual_kind=%0d expected=none", cyc, kind);
         return;
      end
      e = exp_q.pop_front();
      chk("evt_kind", 32'(kind), 32'(e.kind));
      chk("evt_cycle", 32'(cyc), 32'(e.cyc));
      if (kind == K_ENTER) begin
         chk("enter_cause", o_int_cause, e.cause);
         chk("enter_pc", o_int_pc, e.pc);
         chk("enter_mtval", o_int_mtval, e.tval);
         chk("enter_flush", 32'(o_flush), 32'd1);
      end else if (kind == K_EXIT) begin
         chk("exit_flush", 32'(o_flush), 32'd1);
      end else begin
         chk("redirect_pc", o_redirect_pc, e.target);
         chk("redirect_stall", 32'(o_stall), 32'd1);
      end
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         if (o_interrupt_enter) take_evt(K_ENTER);
         if (o_interrupt_exit)  take_evt(K_EXIT);
         if (o_redirect)        take_evt(K_REDIR);
      end
   end

   // ---- stimulus helpers ----
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_commit();
      if (commit_en && ($urandom_range(0, 2) == 0)) begin
         i_commit_valid = 1'b1;
         i_commit_npc   = $urandom() & 32'hFFFF_FFFC;
         last_npc       = i_commit_npc;
      end else begin
         i_commit_valid = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive_commit();
         tick();
      end
      i_commit_valid = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_stall"}, 32'(o_stall), 32'd0);
      chk({tag, "_flush"}, 32'(o_flush), 32'd0);
      chk({tag, "_redirect"}, 32'(o_redirect), 32'd0);
      chk({tag, "_enter"}, 32'(o_interrupt_enter), 32'd0);
      chk({tag, "_exit"}, 32'(o_interrupt_exit), 32'd0);
      chk({tag, "_rpc"}, o_redirect_pc, 32'd0);
      chk({tag, "_cause"}, o_int_cause, 32'd0);
      chk({tag, "_ipc"}, o_int_pc, 32'd0);
      chk({tag, "_mtval"}, o_int_mtval, 32'd0);
   endtask

   task automatic exc_txn(input logic [3:0] c, input logic [31:0] pc, input logic [31:0] tv,
                          input logic with_mret);
      int n;
      n = cyc;
      i_exc_valid = 1'b1; i_exc_cause = c; i_exc_pc = pc; i_exc_tval = tv;
      i_mret = with_mret;
      drive_commit();
      push(K_ENTER, n + 1, {28'b0, c}, pc, tv, 32'd0);
      push(K_REDIR, n + 2, 32'd0, 32'd0, 32'd0, tgt_f(1'b0, c));
      tick();
      i_exc_valid = 1'b0; i_mret = 1'b0;
      idle(4);
   endtask

   task automatic mret_txn();
      int n;
      n = cyc;
      i_mret = 1'b1;
      drive_commit();
      push(K_EXIT, n + 1, 32'd0, 32'd0, 32'd0, 32'd0);
      push(K_REDIR, n + 2, 32'd0, 32'd0, 32'd0, i_mepc);
      tick();
      i_mret = 1'b0;
      idle(4);
   endtask

   // Interrupt taken; pipe_empty rises k cycles into the drain.
   task automatic irq_txn(input logic e, input logic s, input logic t, input int k);
      int n, st, d;
      n  = cyc;
      st = n + 1 + L;
      d  = (k < DM - 1) ? st + k : st + DM - 1;
      i_irq_ext = e; i_irq_soft = s; i_irq_timer = t;
      while (cyc <= d) begin
         i_pipe_empty = (cyc >= st + k);
         drive_commit();
         if (cyc == d) begin
            push(K_ENTER, d + 1, {1'b1, 27'b0, code_f(e, s)}, last_npc, 32'd0, 32'd0);
            push(K_REDIR, d + 2, 32'd0, 32'd0, 32'd0, tgt_f(1'b1, code_f(e, s)));
         end
         @(negedge clk);
         chk("drain_stall", 32'(o_stall), (cyc >= st) ? 32'd1 : 32'd0);
         tick();
      end
      i_irq_ext = 1'b0; i_irq_soft = 1'b0; i_irq_timer = 1'b0; i_pipe_empty = 1'b0;
      idle(5);
   endtask

   // Interrupt withdrawn j cycles into the drain: back to IDLE, no strobe.
   task automatic drop_txn(input logic e, input logic s, input logic t, input int j);
      int st;
      st = cyc + 1 + L;
      i_irq_ext = e; i_irq_soft = s; i_irq_timer = t; i_pipe_empty = 1'b0;
      while (cyc < st + j) begin
         drive_commit();
         tick();
      end
      i_irq_ext = 1'b0; i_irq_soft = 1'b0; i_irq_timer = 1'b0;
      while (cyc <= st + j + L + 1) begin
         drive_commit();
         @(negedge clk);
         chk("drop_stall", 32'(o_stall), (cyc <= st + j + L) ? 32'd1 : 32'd0);
         tick();
      end
      idle(3);
   endtask

   // Exception arrives j cycles into an interrupt drain.
   task automatic exc_mid_txn(input logic e, input logic s, input logic t, input int j,
                              input logic [3:0] c, input logic [31:0] pc,
                              input logic [31:0] tv);
      int st;
      st = cyc + 1 + L;
      i_irq_ext = e; i_irq_soft = s; i_irq_timer = t; i_pipe_empty = 1'b0;
      while (cyc < st + j) begin
         drive_commit();
         tick();
      end
      i_irq_ext = 1'b0; i_irq_soft = 1'b0; i_irq_timer = 1'b0;
      i_exc_valid = 1'b1; i_exc_cause = c; i_exc_pc = pc; i_exc_tval = tv;
      drive_commit();
      push(K_ENTER, st + j + 1, {28'b0, c}, pc, tv, 32'd0);
      push(K_REDIR, st + j + 2, 32'd0, 32'd0, 32'd0, tgt_f(1'b0, c));
      @(negedge clk);
      chk("excmid_stall", 32'(o_stall), 32'd1);
      tick();
      i_exc_valid = 1'b0;
      idle(5);
   endtask

   task automatic reset_mid_txn();
      i_exc_valid = 1'b1; i_exc_cause = 4'd6; i_exc_pc = 32'h55; i_exc_tval = 32'h66;
      i_commit_valid = 1'b0;
      tick();
      i_exc_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      last_npc = RPC;
      @(negedge clk);
      check_zero("rst_mid");
      tick();
      idle(3);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cycle=%0d actual=timeout expected=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      i_mstatus_mie = 1'b0; i_mie = 32'd0; i_mtvec = 32'd0; i_mepc = 32'd0;
      i_irq_ext = 1'b0; i_irq_soft = 1'b0; i_irq_timer = 1'b0;
      i_exc_valid = 1'b0; i_exc_cause = 4'd0; i_exc_pc = 32'd0; i_exc_tval = 32'd0;
      i_mret = 1'b0; i_commit_valid = 1'b0; i_commit_npc = 32'd0; i_pipe_empty = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      check_zero("reset");
      tick();

      // Resume PC straight out of reset, no commits yet.
      commit_en = 1'b0;
      i_mstatus_mie = 1'b1; i_mie = 32'h800; i_mtvec = 32'h100;
      irq_txn(1'b1, 1'b0, 1'b0, 2);

      // Direct-mode exception.
      exc_txn(4'd2, 32'h40, 32'hDEAD, 1'b0);

      // Vectored timer interrupt after a commit of 0x88.
      i_mie = 32'h80; i_mtvec = 32'h201;
      i_commit_valid = 1'b1; i_commit_npc = 32'h88; last_npc = 32'h88;
      tick();
      i_commit_valid = 1'b0;
      irq_txn(1'b0, 1'b0, 1'b1, 3);
      commit_en = 1'b1;

      // Priority.
      i_mtvec = 32'h100; i_mie = 32'hFFFF_FFFF;
      irq_txn(1'b1, 1'b1, 1'b1, 0);
      i_mie = 32'h88;
      irq_txn(1'b1, 1'b1, 1'b1, 1);

      // MRET, and exception beating a same-cycle MRET.
      i_mepc = 32'h1234;
      mret_txn();
      exc_txn(4'd3, 32'h200, 32'h0, 1'b1);

      // Drain boundaries.
      i_mie = 32'h80; i_mtvec = 32'h301;
      irq_txn(1'b0, 1'b0, 1'b1, DM + 5);
      drop_txn(1'b0, 1'b0, 1'b1, 5);
      exc_mid_txn(1'b0, 1'b0, 1'b1, 4, 4'd5, 32'h700, 32'hBEEF);

      reset_mid_txn();

      for (int it = 0; it < 40; it++) begin
         int   sel;
         logic e, s, t;
         i_mtvec = $urandom();
         i_mepc  = $urandom();
         i_mstatus_mie = 1'b1;
         i_mie = $urandom();
         e = 1'($urandom()); s = 1'($urandom()); t = 1'($urandom());
         if (!pend_f(e, s, t)) begin
            t = 1'b1;
            i_mie[7] = 1'b1;
         end
         sel = int'($urandom_range(0, 4));
         case (sel)
            0: exc_txn(4'($urandom()), $urandom(), $urandom(), 1'($urandom()));
            1: mret_txn();
            2: irq_txn(e, s, t, int'($urandom_range(0, DM + 2)));
            3: drop_txn(e, s, t, int'($urandom_range(0, DM - 2 - L)));
            default: exc_mid_txn(e, s, t, int'($urandom_range(0, DM - 2)), 4'($urandom()),
                                 $urandom(), $urandom());
         endcase
      end

      idle(4);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Trap/return sequencer on the initiating side of the machine-mode CSR file.
- Arbitrates synchronous exceptions, external/timer/software interrupts and MRET.
- Drains and flushes the pipeline, then drives the CSR file's interrupt_enter/interrupt_exit strobes with cause/pc/mtval.
- Redirects fetch to the mtvec-derived handler or to mepc.

Parameters:
- RESET_PC, 32'h0000_0000, initial value of the tracked resume PC.
- DRAIN_MAX, 16, maximum drain cycles before an interrupt entry is forced (range 2..255).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_mstatus_mie  in  1  mstatus[3] from CSR file
- i_mie  in  32  mie register
- i_mtvec  in  32  mtvec register
- i_mepc  in  32  mepc register
- i_irq_ext / i_irq_soft / i_irq_timer  in  1 each  level interrupt requests
- i_exc_valid  in  1  synchronous exception from execute stage
- i_exc_cause  in  4  exception code
- i_exc_pc  in  32  faulting PC
- i_exc_tval  in  32  faulting value
- i_mret  in  1  MRET in execute stage
- i_commit_valid  in  1  instruction retired this cycle
- i_commit_npc  in  32  architectural next PC of the retired instruction
- i_pipe_empty  in  1  no instruction in flight past fetch
- o_stall  out  1  hold fetch/issue
- o_flush  out  1  kill in-flight instructions
- o_redirect  out  1  load o_redirect_pc into PC
- o_redirect_pc  out  32  target PC
- o_interrupt_enter  out  1  one-cycle strobe to CSR file
- o_interrupt_exit  out  1  one-cycle strobe to CSR file
- o_int_cause  out  32  mcause value
- o_int_pc  out  32  mepc value
- o_int_mtval  out  32  mtval value

Behaviour:
- Reset: all outputs 0, state IDLE, resume PC = RESET_PC, drain counter 0.
- Resume PC register: loads i_commit_npc on every cycle with i_commit_valid=1.
- Interrupt pending condition: i_mstatus_mie & (irq & i_mie bit).
  - Bits used: ext=11, soft=3, timer=7.
  - Priority: ext > soft > timer.
  - Cause = {1'b1, 27'b0, code}.
- States: IDLE, DRAIN, ENTER, EXIT, REDIRECT; all outputs registered.
- IDLE:
  - i_exc_valid → ENTER. Capture cause {28'b0, i_exc_cause}, pc=i_exc_pc, mtval=i_exc_tval.
  - Else i_mret → EXIT.
  - Else interrupt pending → DRAIN with o_stall=1 and counter cleared.
  - Priority within IDLE: exception > MRET > interrupt.
- DRAIN:
  - o_stall=1; counter increments each cycle.
  - i_exc_valid → ENTER on the exception (interrupt abandoned, re-evaluated later).
  - Else if pending clears → IDLE, o_stall=0.
  - Else if i_pipe_empty or counter==DRAIN_MAX-1 → ENTER with cause from the priority encoder at that cycle, pc=resume PC (after any same-cycle commit), mtval=0.
- ENTER (1 cycle): o_interrupt_enter=1, o_flush=1, o_stall=1, o_int_* valid → REDIRECT.
- EXIT (1 cycle): o_interrupt_exit=1, o_flush=1, o_stall=1; latch i_mepc → REDIRECT.
- REDIRECT (1 cycle): o_redirect=1, o_stall=1 → IDLE.
  - After EXIT, target = latched mepc.
  - After ENTER, target comes from i_mtvec (sampled in this cycle, the CSR file is already updated).
  - Exception, or mtvec[1:0]!=01: target = {mtvec[31:2],2'b00}.
  - Vectored interrupt: target = {mtvec[31:2],2'b00} + 4*code, with mod-2^32 wrap.
- Latency:
  - Exception at cycle N: enter strobe N+1, redirect N+2.
  - MRET: exit strobe N+1, redirect N+2.
- Inputs arriving in ENTER/EXIT/REDIRECT are ignored; the source must hold or re-raise.
- rst mid-sequence returns to IDLE immediately; no strobe is issued in that cycle.

Optional Feature:
- Macro: TRAP_IRQ_SYNC_EN.
- Defined: each i_irq_* passes through a 2-flop synchronizer (reset 0) before masking, adding 2 cycles of interrupt latency.
- Undefined: irq inputs are used directly (must be synchronous to clk).

Decomposition:
- Package rv_trap_pkg holds:
  - state enum;
  - interrupt codes (MEI=11, MSI=3, MTI=7);
  - MTVEC_DIRECT=2'b00, MTVEC_VECTORED=2'b01;
  - cause-word builder function.
- Sub-module irq_prio_enc: combinational masked priority encoder with outputs pending and code[3:0]. Instantiate once.

Test Plan:
- Exception path: mtvec=0x100 (direct); i_exc_valid, cause=2, pc=0x40, tval=0xDEAD at cycle N → enter=1 at N+1 with o_int_cause=2, pc=0x40, mtval=0xDEAD; redirect=1 at N+2 with o_redirect_pc=0x100.
- Vectored timer interrupt: mstatus_mie=1, mie=0x80, mtvec=0x201, last commit npc=0x88, irq_timer=1, pipe_empty after 3 cycles → stall held through drain; enter with cause=0x80000007, pc=0x88; redirect_pc=0x21C.
- Interrupt priority: ext+timer+soft all set, mie=0xFFFF_FFFF → cause=0x8000000B; with mie=0x88 → cause=0x80000003.
- MRET: mepc=0x1234, i_mret pulse → exit=1 at N+1, redirect_pc=0x1234 at N+2. Same-cycle i_exc_valid+i_mret → enter taken, no exit strobe.
- Drain boundaries:
  - pipe_empty held 0 → enter forced at DRAIN_MAX cycles.
  - irq dropped mid-drain → IDLE, stall=0, no strobe.
  - Exception mid-drain → exception cause used.
- Reset mid-trap: rst asserted during ENTER → next cycle all outputs 0, IDLE; with TRAP_IRQ_SYNC_EN, interrupt entry is delayed by exactly 2 cycles versus the undefined build.
